m2v_seq_ctrl: RTL and testbench

//  Job sequencer for the 16-lane systolic matrix-vector (M2V) array.
//  - Accepts one start per job and holds the array enable for the full systolic fill + drain.
//  - Asks upstream to hold M/V operands stable while the job runs.
//  - Captures the MV result bus on the last enabled cycle and offers it on a valid/ready port.
//  - Handles abort, back-to-back jobs, overrun flagging and job counting.

---
 rtl/m2v_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_m2v_seq_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m2v_seq_ctrl.sv
// ============================================================================
// m2v_seq_ctrl
// ----------------------------------------------------------------------------
// Job sequencer for the DIMENSION-lane systolic matrix-vector (M2V) array.
//
// One accepted start runs one job. The array enable stays high for RUN_LEN
// consecutive cycles, which covers systolic fill, drain and the array output
// register. On the edge that ends the last enabled cycle, the MV result bus is
// captured. The captured result is then offered on a valid/ready port. A new
// job may start in the same cycle that the result is accepted, so there is no
// idle cycle between jobs.
//
// Optional feature macro: M2V_CTRL_PERF_EN
//   defined   : perf_stall_o counts DONE cycles with res_ready_i=0 (saturating)
//   undefined : perf_stall_o is tied to 0 and no counter is built
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        job request, taken when start_ready_o=1
//   start_ready_o  IDLE, or DONE with the result being accepted this cycle
//   abort_i        synchronous abort; highest priority, discards pending result
//   m2v_en_o       array enable (registered)
//   hold_ops_o     upstream must keep M/V operands stable (same as m2v_en_o)
//   m2v_mv_i       array MV result bus (DIMENSION*WIDTH bits)
//   res_valid_o    captured result available
//   res_ready_i    consumer accepts result
//   res_data_o     captured result (DIMENSION*WIDTH bits)
//   busy_o         sequencer is not IDLE
//   err_overrun_o  sticky: start seen while start_ready_o=0
//   clr_err_i      clears err_overrun_o (wins over a coincident overrun)
//   job_cnt_o      number of accepted results, wraps at 16 bits
//   perf_stall_o   result-backpressure cycle counter (see macro above)
// ============================================================================
module m2v_seq_ctrl #(
    parameter int DIMENSION = 16,
    parameter int WIDTH     = 8,
    parameter int OUT_LAT   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    output logic                         start_ready_o,
    input  logic                         abort_i,
    output logic                         m2v_en_o,
    output logic                         hold_ops_o,
    input  logic [DIMENSION*WIDTH-1:0]   m2v_mv_i,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [DIMENSION*WIDTH-1:0]   res_data_o,
    output logic                         busy_o,
    output logic                         err_overrun_o,
    input  logic                         clr_err_i,
    output logic [15:0]                  job_cnt_o,
    output logic [31:0]                  perf_stall_o
);

    // Enabled cycles per job: fill (DIMENSION-1) + drain (DIMENSION) + output regs.
    localparam int RUN_LEN = 2 * DIMENSION - 1 + OUT_LAT;
    localparam int CNT_W   = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);
    localparam int DW      = DIMENSION * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              en_q, en_d;
    logic [DW-1:0]     res_data_q;
    logic              err_q, err_d;
    logic [15:0]       job_cnt_q;
    logic              capture;
    logic              job_inc;
    logic              start_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        job_inc     = 1'b0;
        start_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && res_ready_i);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // Last enabled cycle: sample the array output and stop the array.
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready_i) begin
                    job_inc = 1'b1;
                    if (start_i) begin
                        // Back-to-back: hand over straight into the next job.
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a capture or a handshake.
        if (abort_i) begin
            state_d = ST_IDLE;
            capture = 1'b0;
            job_inc = 1'b0;
        end

        // Enable is registered from the next state so it lines up with RUN exactly.
        en_d = (state_d == ST_RUN);

        // Sticky overrun; a clear in the same cycle takes precedence.
        err_d = err_q;
        if (start_i && !start_ready && !abort_i) begin
            err_d = 1'b1;
        end
        if (clr_err_i) begin
            err_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            res_data_q <= '0;
            err_q      <= 1'b0;
            job_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            err_q   <= err_d;
            if (capture) begin
                res_data_q <= m2v_mv_i;
            end
            if (job_inc) begin
                job_cnt_q <= job_cnt_q + 16'd1;
            end
        end
    end

`ifdef M2V_CTRL_PERF_EN
    // Backpressure counter: cycles where a result waits on the consumer.
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if ((state_q == ST_DONE) && !res_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_stall_o = stall_q;
`else
    assign perf_stall_o = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign start_ready_o = start_ready;
    assign m2v_en_o      = en_q;
    assign hold_ops_o    = en_q;
    assign res_valid_o   = (state_q == ST_DONE);
    assign res_data_o    = res_data_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign err_overrun_o = err_q;
    assign job_cnt_o     = job_cnt_q;

endmodule

// File: tb/tb_m2v_seq_ctrl.sv
// ============================================================================
// tb_m2v_seq_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for m2v_seq_ctrl. A reference model describes each job
// as a number of enabled cycles still to run plus a "result pending" flag.
// Directed scenarios (single job, back-to-back, stall, abort, overrun, mid-job
// reset) are followed by a randomized phase. Each accepted result prints one
// line.
// ============================================================================
module tb_m2v_seq_ctrl;

    localparam int DIMENSION = 16;
    localparam int WIDTH     = 8;
    localparam int OUT_LAT   = 1;
    localparam int RUN_LEN   = 2 * DIMENSION - 1 + OUT_LAT;
    localparam int DW        = DIMENSION * WIDTH;

    logic            clk_i;
    logic            rst_ni;
    logic            start_i;
    logic            start_ready_o;
    logic            abort_i;
    logic            m2v_en_o;
    logic            hold_ops_o;
    logic [DW-1:0]   m2v_mv_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [DW-1:0]   res_data_o;
    logic            busy_o;
    logic            err_overrun_o;
    logic            clr_err_i;
    logic [15:0]     job_cnt_o;
    logic [31:0]     perf_stall_o;

    m2v_seq_ctrl #(
        .DIMENSION (DIMENSION),
        .WIDTH     (WIDTH),
        .OUT_LAT   (OUT_LAT)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .start_ready_o (start_ready_o),
        .abort_i       (abort_i),
        .m2v_en_o      (m2v_en_o),
        .hold_ops_o    (hold_ops_o),
        .m2v_mv_i      (m2v_mv_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_data_o    (res_data_o),
        .busy_o        (busy_o),
        .err_overrun_o (err_overrun_o),
        .clr_err_i     (clr_err_i),
        .job_cnt_o     (job_cnt_o),
        .perf_stall_o  (perf_stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------
    // Counters and checker
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: remaining enabled cycles of the current job and
    // whether a captured result is waiting for the consumer.
    // ------------------------------------------------------------------
    int              m_left;
    bit              m_pend;
    logic [DW-1:0]   m_res;
    logic [15:0]     m_job;
    bit              m_err;
    logic [31:0]     m_stall;

    task automatic model_reset();
        m_left  = 0;
        m_pend  = 1'b0;
        m_res   = '0;
        m_job   = '0;
        m_err   = 1'b0;
        m_stall = '0;
    endtask

    // Snapshot of registered outputs at the latest negedge.
    bit          obs_en;
    bit          obs_valid;
    bit          obs_busy;
    bit          obs_err;
    logic [15:0] obs_job;
    logic [31:0] obs_perf;

    // One clock cycle: compare registered outputs, drive inputs, compare
    // start_ready, then advance the model across the coming rising edge.
    task automatic step(input bit st, input bit ab, input bit rr, input bit ce, input logic [DW-1:0] mv);
        bit busy_m;
        bit ready_m;
        bit ovr;
        logic [31:0] exp_perf;
        @(negedge clk_i);
        obs_en    = m2v_en_o;
        obs_valid = res_valid_o;
        obs_busy  = busy_o;
        obs_err   = err_overrun_o;
        obs_job   = job_cnt_o;
        obs_perf  = perf_stall_o;
`ifdef M2V_CTRL_PERF_EN
        exp_perf = m_stall;
`else
        exp_perf = 32'd0;
`endif
        check_val("m2v_en",      m2v_en_o,      m_left > 0);
        check_val("hold_ops",    hold_ops_o,    m_left > 0);
        check_val("res_valid",   res_valid_o,   m_pend);
        check_val("busy",        busy_o,        (m_left > 0) || m_pend);
        check_val("err_overrun", err_overrun_o, m_err);
        check_val("job_cnt",     job_cnt_o,     m_job);
        check_val("res_data",    res_data_o,    m_res);
        check_val("perf_stall",  perf_stall_o,  exp_perf);

        start_i     = st;
        abort_i     = ab;
        res_ready_i = rr;
        clr_err_i   = ce;
        m2v_mv_i    = mv;
        #1;
        busy_m  = (m_left > 0) || m_pend;
        ready_m = !busy_m || (m_pend && rr);
        check_val("start_ready", start_ready_o, ready_m);

        ovr = st && !ready_m && !ab;
        if (m_pend && !rr && (m_stall != 32'hFFFF_FFFF)) begin
            m_stall = m_stall + 32'd1;
        end
        if (ab) begin
            m_left = 0;
            m_pend = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_res  = mv;
                m_pend = 1'b1;
            end
        end else if (m_pend) begin
            if (rr) begin
                m_job  = m_job + 16'd1;
                m_pend = 1'b0;
                $display("job %0d accepted  data=%h", m_job, m_res);
                if (st) begin
                    m_left = RUN_LEN;
                end
            end
        end else if (st) begin
            m_left = RUN_LEN;
        end
        if (ce) begin
            m_err = 1'b0;
        end else if (ovr) begin
            m_err = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] rand_mv();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reset pulled low between edges while a job is running.
    task automatic reset_mid_cycle();
        @(negedge clk_i);
        start_i     = 1'b0;
        abort_i     = 1'b0;
        res_ready_i = 1'b0;
        clr_err_i   = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("rst_async_en",    m2v_en_o,    1'b0);
        check_val("rst_async_busy",  busy_o,      1'b0);
        check_val("rst_async_valid", res_valid_o, 1'b0);
        check_val("rst_async_job",   job_cnt_o,   16'd0);
        check_val("rst_async_data",  res_data_o,  128'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    localparam logic [DW-1:0] MV_T1 = 128'h0102030405060708090a0b0c0d0e0f10;

    // Single-job pattern: returns first cycle with res_valid and enabled count.
    task automatic single_job(output int first_valid, output int en_cycles);
        first_valid = -1;
        en_cycles   = 0;
        for (int i = 0; i < 40; i++) begin
            step(i == 0, 1'b0, 1'b1, 1'b0, MV_T1);
            if (obs_en) en_cycles++;
            if (obs_valid && first_valid < 0) first_valid = i;
        end
    endtask

    initial begin
        int          fv;
        int          enc;
        int          fall_at;
        int          rise_at;
        bit          prev_en;
        logic [31:0] perf_base;
        logic [15:0] job_base;
        logic [DW-1:0] data_hold;

        rst_ni      = 1'b0;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        res_ready_i = 1'b0;
        clr_err_i   = 1'b0;
        m2v_mv_i    = '0;
        model_reset();

        // Reset values
        @(negedge clk_i);
        @(negedge clk_i);
        check_val("rst_en",    m2v_en_o,      1'b0);
        check_val("rst_valid", res_valid_o,   1'b0);
        check_val("rst_busy",  busy_o,        1'b0);
        check_val("rst_err",   err_overrun_o, 1'b0);
        check_val("rst_job",   job_cnt_o,     16'd0);
        check_val("rst_perf",  perf_stall_o,  32'd0);
        check_val("rst_data",  res_data_o,    128'd0);
        rst_ni = 1'b1;

        // 1: single job
        single_job(fv, enc);
        check_val("t1_first_valid", fv, 33);
        check_val("t1_en_cycles",   enc, RUN_LEN);
        check_val("t1_res_data",    res_data_o, MV_T1);
        check_val("t1_job_cnt",     job_cnt_o, 16'd1);

        // 2: back-to-back with start held high
        fall_at = -1;
        rise_at = -1;
        prev_en = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, rand_mv());
            if (i > 0 && prev_en && !obs_en && fall_at < 0) fall_at = i;
            if (!prev_en && obs_en && fall_at >= 0 && rise_at < 0) rise_at = i;
            prev_en = obs_en;
        end
        check_val("t2_gap_len", rise_at - fall_at, 1);
        check_val("t2_fall_at", fall_at, 33);
        check_val("t2_jobs",    job_cnt_o, 16'd3);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, 1'b0, rand_mv());
        step(1'b0, 1'b0, 1'b1, 1'b1, rand_mv());   // clear overruns from held start

        // 3: stall for 10 cycles in DONE
        perf_base = perf_stall_o;
        for (int i = 0; i < 43; i++) begin
            step(i == 0, 1'b0, 1'b0, 1'b0, (i == 32) ? MV_T1 : rand_mv());
            if (i == 34) data_hold = res_data_o;
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, rand_mv());
        check_val("t3_valid_held", obs_valid, 1'b1);
        check_val("t3_data_stable", res_data_o, data_hold);
        check_val("t3_data", res_data_o, MV_T1);
`ifdef M2V_CTRL_PERF_EN
        check_val("t3_perf", obs_perf - perf_base, 32'd10);
`else
        check_val("t3_perf", obs_perf, 32'd0);
`endif
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, rand_mv());

        // 4: abort at cnt=7
        job_base = job_cnt_o;
        for (int i = 0; i < 50; i++) begin
            step(i == 0, i == 8, 1'b1, 1'b0, rand_mv());
            if (i == 9) begin
                check_val("t4_en_after_abort",   obs_en,   1'b0);
                check_val("t4_busy_after_abort", obs_busy, 1'b0);
            end
            if (i > 8) check_val("t4_no_valid", obs_valid, 1'b0);
        end
        check_val("t4_job_unchanged", job_cnt_o, job_base);

        // 5: overrun at cnt=5, job continues, then clear
        for (int i = 0; i < 40; i++) begin
            step((i == 0) || (i == 6), 1'b0, 1'b1, 1'b0, (i == 32) ? MV_T1 : rand_mv());
            if (i == 7)  check_val("t5_err_set", obs_err, 1'b1);
            if (i == 20) check_val("t5_en_cont", obs_en,  1'b1);
        end
        check_val("t5_result", res_data_o, MV_T1);
        step(1'b0, 1'b0, 1'b1, 1'b1, rand_mv());
        step(1'b0, 1'b0, 1'b1, 1'b0, rand_mv());
        check_val("t5_err_clr", obs_err, 1'b0);

        // 6: async reset mid-RUN, then a fresh single job
        for (int i = 0; i < 12; i++) step(i == 0, 1'b0, 1'b1, 1'b0, rand_mv());
        reset_mid_cycle();
        single_job(fv, enc);
        check_val("t6_first_valid", fv, 33);
        check_val("t6_en_cycles",   enc, RUN_LEN);
        check_val("t6_job_cnt",     job_cnt_o, 16'd1);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0,
                 rand_mv());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
